// File: rtl/camera_capture_generic_if.sv
// Camera capture bus: raw camera inputs plus assembled pixel, coordinate and status outputs.
// Latency: none (wiring only); widths are set by the instantiating scope to match the capture block.
// Backpressure: none; master drives camera signals, slave (capture block) drives pixel/status.
interface camera_capture_generic_if #(
  parameter int PW  = 16,
  parameter int AW  = 19,
  parameter int XW  = 10,
  parameter int YW  = 9,
  parameter int FCW = 16
);
  logic [7:0]     D;
  logic           HREF;
  logic           VSYNC;
  logic           CAPTURE_EN;
  logic [PW-1:0]  o_pixel;
  logic           DV;
  logic [AW-1:0]  w_addr;
  logic [XW-1:0]  pixel_x;
  logic [YW-1:0]  pixel_y;
  logic           SOF;
  logic           FRAME_DONE;
  logic           FRAME_ERR;
  logic           LINE_ERR;
  logic [FCW-1:0] frame_count;

  modport master (
    output D, HREF, VSYNC, CAPTURE_EN,
    input  o_pixel, DV, w_addr, pixel_x, pixel_y, SOF, FRAME_DONE, FRAME_ERR, LINE_ERR, frame_count
  );

  modport slave (
    input  D, HREF, VSYNC, CAPTURE_EN,
    output o_pixel, DV, w_addr, pixel_x, pixel_y, SOF, FRAME_DONE, FRAME_ERR, LINE_ERR, frame_count
  );
endinterface

// File: rtl/camera_capture_generic.sv
// Camera parallel-bus capture: assembles bytes into pixels tagged with x/y/linear address.
// Latency: 1 PCLK from the edge sampling a pixel's last byte to DV; status pulses 1 PCLK after the event.
// Backpressure: none; the camera free-runs and each in-range pixel is presented exactly once.
module camera_capture_generic #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int BYTES_PER_PIXEL   = 2,
  parameter int BYTE_SWAP         = 0,
  parameter int SNAPSHOT          = 0,
  parameter int FRAME_CNT_W       = 16
) (
  input logic                     PCLK,
  input logic                     RST,
  camera_capture_generic_if.slave cam
);
  localparam int W  = RESOLUTION_WIDTH;
  localparam int H  = RESOLUTION_HEIGHT;
  localparam int PW = 8 * BYTES_PER_PIXEL;
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int AW = (W * H > 1) ? $clog2(W * H) : 1;
  // Counters go one past the expected count so over-long lines/frames are still detectable.
  localparam int CW = $clog2(W + 2);
  localparam int LW = $clog2(H + 2);
  localparam logic [CW-1:0] PIX_SAT  = CW'(W + 1);
  localparam logic [LW-1:0] LINE_SAT = LW'(H + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, ACTIVE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   h_q, v_q;
  logic                   snap_done_q;
  logic                   phase_q;
  logic [7:0]             byte0_q;
  logic                   line_act_q;
  logic [CW-1:0]          pix_cnt_q;
  logic [LW-1:0]          line_cnt_q;
  logic [PW-1:0]          pixel_q;
  logic                   dv_q, sof_q, fdone_q, ferr_q, lerr_q;
  logic [AW-1:0]          addr_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic [FRAME_CNT_W-1:0] fcnt_q;

  logic          v_rise, v_fall, h_fall;
  logic          sample, last_byte, in_range, close_line, frame_end, start_frame;
  logic [CW-1:0] pix_cnt_inc;
  logic [LW-1:0] line_cnt_inc, line_cnt_final;
  logic [AW-1:0] addr_calc;
  logic [PW-1:0] pix_asm;

  assign v_rise    = cam.VSYNC & ~v_q;
  assign v_fall    = ~cam.VSYNC & v_q;
  assign h_fall    = h_q & ~cam.HREF;
  assign sample    = (state_q == ACTIVE) & ~cam.VSYNC & cam.HREF;
  assign last_byte = sample & ((BYTES_PER_PIXEL == 1) | phase_q);
  assign in_range  = (pix_cnt_q < CW'(W)) & (line_cnt_q < LW'(H));
  // A frame ending while HREF is still high closes the open line in the same cycle.
  assign close_line  = (state_q == ACTIVE) & line_act_q & (h_fall | (v_rise & cam.HREF));
  assign frame_end   = (state_q == ACTIVE) & v_rise;
  assign start_frame = (state_q == WAIT_FRAME) & (state_d == ACTIVE);

  assign pix_cnt_inc    = (pix_cnt_q == PIX_SAT) ? pix_cnt_q : pix_cnt_q + CW'(1);
  assign line_cnt_inc   = (line_cnt_q == LINE_SAT) ? line_cnt_q : line_cnt_q + LW'(1);
  assign line_cnt_final = close_line ? line_cnt_inc : line_cnt_q;
  assign addr_calc      = AW'(line_cnt_q) * AW'(W) + AW'(pix_cnt_q);

  if (BYTES_PER_PIXEL == 1) begin : g_bpp1
    assign pix_asm = cam.D;
  end else if (BYTE_SWAP != 0) begin : g_swap
    assign pix_asm = {cam.D, byte0_q};
  end else begin : g_noswap
    assign pix_asm = {byte0_q, cam.D};
  end

  // Next-state logic. In snapshot mode a finished frame blocks re-entry to ACTIVE
  // until CAPTURE_EN drops, so a held enable yields a single frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (cam.CAPTURE_EN) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!cam.CAPTURE_EN)           state_d = IDLE;
        else if (v_fall && !snap_done_q) state_d = ACTIVE;
      end
      ACTIVE:     if (v_rise) state_d = ((SNAPSHOT != 0) || !cam.CAPTURE_EN) ? IDLE : WAIT_FRAME;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Edge detectors, byte assembly, line/frame counters and registered outputs.
  always_ff @(posedge PCLK) begin
    if (RST) begin
      h_q <= 1'b0;  v_q <= 1'b0;  snap_done_q <= 1'b0;
      phase_q <= 1'b0;  byte0_q <= '0;  line_act_q <= 1'b0;
      pix_cnt_q <= '0;  line_cnt_q <= '0;
      pixel_q <= '0;  dv_q <= 1'b0;  addr_q <= '0;  x_q <= '0;  y_q <= '0;
      sof_q <= 1'b0;  fdone_q <= 1'b0;  ferr_q <= 1'b0;  lerr_q <= 1'b0;  fcnt_q <= '0;
    end else begin
      h_q     <= cam.HREF;
      v_q     <= cam.VSYNC;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
      fdone_q <= 1'b0;
      ferr_q  <= 1'b0;
      lerr_q  <= 1'b0;

      if (!cam.CAPTURE_EN)                    snap_done_q <= 1'b0;
      else if (frame_end && (SNAPSHOT != 0)) snap_done_q <= 1'b1;

      if (start_frame) begin
        phase_q <= 1'b0;  line_act_q <= 1'b0;  pix_cnt_q <= '0;  line_cnt_q <= '0;
      end

      if (sample) begin
        line_act_q <= 1'b1;
        if (last_byte) begin
          phase_q   <= 1'b0;
          pix_cnt_q <= pix_cnt_inc;
          if (in_range) begin
            pixel_q <= pix_asm;
            dv_q    <= 1'b1;
            addr_q  <= addr_calc;
            x_q     <= XW'(pix_cnt_q);
            y_q     <= YW'(line_cnt_q);
            sof_q   <= (pix_cnt_q == '0) && (line_cnt_q == '0);
          end
        end else begin
          phase_q <= 1'b1;
          byte0_q <= cam.D;
        end
      end

      // Any half-assembled pixel is dropped when the line closes.
      if (close_line) begin
        lerr_q     <= (pix_cnt_q != CW'(W)) || phase_q;
        phase_q    <= 1'b0;
        line_act_q <= 1'b0;
        pix_cnt_q  <= '0;
        line_cnt_q <= line_cnt_inc;
      end

      if (frame_end) begin
        fdone_q <= 1'b1;
        ferr_q  <= (line_cnt_final != LW'(H));
        fcnt_q  <= fcnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign cam.o_pixel     = pixel_q;
  assign cam.DV          = dv_q;
  assign cam.w_addr      = addr_q;
  assign cam.pixel_x     = x_q;
  assign cam.pixel_y     = y_q;
  assign cam.SOF         = sof_q;
  assign cam.FRAME_DONE  = fdone_q;
  assign cam.FRAME_ERR   = ferr_q;
  assign cam.LINE_ERR    = lerr_q;
  assign cam.frame_count = fcnt_q;
endmodule

// File: tb/tb_camera_capture_generic.sv
// Directed bench for camera_capture_generic at 4x3: four instances (BPP2, BPP2 swapped,
// BPP2 snapshot, BPP1) share one camera stimulus; a negedge monitor logs each instance's
// pixels and status pulses, and scenario tasks compare against hand-computed values.
module tb_camera_capture_generic;
  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       href, vsync, cen;

  always #5 pclk = ~pclk;

  camera_capture_generic_if #(.PW(16), .AW(4), .XW(2), .YW(2), .FCW(16)) if_a ();
  camera_capture_generic_if #(.PW(16), .AW(4), .XW(2), .YW(2), .FCW(16)) if_b ();
  camera_capture_generic_if #(.PW(16), .AW(4), .XW(2), .YW(2), .FCW(16)) if_c ();
  camera_capture_generic_if #(.PW(8),  .AW(4), .XW(2), .YW(2), .FCW(16)) if_d ();

  assign {if_a.D, if_a.HREF, if_a.VSYNC, if_a.CAPTURE_EN} = {d, href, vsync, cen};
  assign {if_b.D, if_b.HREF, if_b.VSYNC, if_b.CAPTURE_EN} = {d, href, vsync, cen};
  assign {if_c.D, if_c.HREF, if_c.VSYNC, if_c.CAPTURE_EN} = {d, href, vsync, cen};
  assign {if_d.D, if_d.HREF, if_d.VSYNC, if_d.CAPTURE_EN} = {d, href, vsync, cen};

  camera_capture_generic #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(3), .BYTES_PER_PIXEL(2),
    .BYTE_SWAP(0), .SNAPSHOT(0), .FRAME_CNT_W(16)) u_a (.PCLK(pclk), .RST(rst), .cam(if_a));
  camera_capture_generic #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(3), .BYTES_PER_PIXEL(2),
    .BYTE_SWAP(1), .SNAPSHOT(0), .FRAME_CNT_W(16)) u_b (.PCLK(pclk), .RST(rst), .cam(if_b));
  camera_capture_generic #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(3), .BYTES_PER_PIXEL(2),
    .BYTE_SWAP(0), .SNAPSHOT(1), .FRAME_CNT_W(16)) u_c (.PCLK(pclk), .RST(rst), .cam(if_c));
  camera_capture_generic #(.RESOLUTION_WIDTH(4), .RESOLUTION_HEIGHT(3), .BYTES_PER_PIXEL(1),
    .BYTE_SWAP(0), .SNAPSHOT(0), .FRAME_CNT_W(16)) u_d (.PCLK(pclk), .RST(rst), .cam(if_d));

  // Per-instance views of the outputs so the monitor can loop over instances.
  logic        dv_s[4], sof_s[4], fd_s[4], fe_s[4], le_s[4];
  logic [15:0] pix_s[4], fc_s[4];
  logic [3:0]  addr_s[4];
  logic [1:0]  x_s[4], y_s[4];

  assign {dv_s[0], sof_s[0], fd_s[0], fe_s[0], le_s[0]} = {if_a.DV, if_a.SOF, if_a.FRAME_DONE, if_a.FRAME_ERR, if_a.LINE_ERR};
  assign {dv_s[1], sof_s[1], fd_s[1], fe_s[1], le_s[1]} = {if_b.DV, if_b.SOF, if_b.FRAME_DONE, if_b.FRAME_ERR, if_b.LINE_ERR};
  assign {dv_s[2], sof_s[2], fd_s[2], fe_s[2], le_s[2]} = {if_c.DV, if_c.SOF, if_c.FRAME_DONE, if_c.FRAME_ERR, if_c.LINE_ERR};
  assign {dv_s[3], sof_s[3], fd_s[3], fe_s[3], le_s[3]} = {if_d.DV, if_d.SOF, if_d.FRAME_DONE, if_d.FRAME_ERR, if_d.LINE_ERR};
  assign {pix_s[0], fc_s[0], addr_s[0], x_s[0], y_s[0]} = {if_a.o_pixel, if_a.frame_count, if_a.w_addr, if_a.pixel_x, if_a.pixel_y};
  assign {pix_s[1], fc_s[1], addr_s[1], x_s[1], y_s[1]} = {if_b.o_pixel, if_b.frame_count, if_b.w_addr, if_b.pixel_x, if_b.pixel_y};
  assign {pix_s[2], fc_s[2], addr_s[2], x_s[2], y_s[2]} = {if_c.o_pixel, if_c.frame_count, if_c.w_addr, if_c.pixel_x, if_c.pixel_y};
  assign {pix_s[3], fc_s[3], addr_s[3], x_s[3], y_s[3]} = {8'h00, if_d.o_pixel, if_d.frame_count, if_d.w_addr, if_d.pixel_x, if_d.pixel_y};

  int          dv_cnt[4]  = '{default: 0};
  int          sof_cnt[4] = '{default: 0};
  int          fd_cnt[4]  = '{default: 0};
  int          fe_cnt[4]  = '{default: 0};
  int          fefd_cnt[4] = '{default: 0};
  int          le_cnt[4]  = '{default: 0};
  logic [15:0] fc_at_fd[4];
  logic [15:0] pix_log[4][256];
  logic [3:0]  addr_log[4][256];
  logic [1:0]  x_log[4][256], y_log[4][256];

  always @(negedge pclk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv_s[k] === 1'b1) begin
        if (dv_cnt[k] < 256) begin
          pix_log[k][dv_cnt[k]]  = pix_s[k];
          addr_log[k][dv_cnt[k]] = addr_s[k];
          x_log[k][dv_cnt[k]]    = x_s[k];
          y_log[k][dv_cnt[k]]    = y_s[k];
        end
        dv_cnt[k]++;
      end
      if (sof_s[k] === 1'b1) sof_cnt[k]++;
      if (fe_s[k] === 1'b1)  fe_cnt[k]++;
      if (le_s[k] === 1'b1)  le_cnt[k]++;
      if (fd_s[k] === 1'b1) begin
        fd_cnt[k]++;
        fc_at_fd[k] = fc_s[k];
        if (fe_s[k] === 1'b1) fefd_cnt[k]++;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int b_dv[4], b_sof[4], b_fd[4], b_fe[4], b_fefd[4], b_le[4];

  task automatic take_base();
    for (int k = 0; k < 4; k++) begin
      b_dv[k] = dv_cnt[k];  b_sof[k] = sof_cnt[k];  b_fd[k] = fd_cnt[k];
      b_fe[k] = fe_cnt[k];  b_fefd[k] = fefd_cnt[k];  b_le[k] = le_cnt[k];
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Drives bytes 1..nb with HREF high, then drops HREF; returns at the HREF-low negedge.
  task automatic send_line(input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge pclk); href = 1'b1; d = 8'(i + 1);
    end
    @(negedge pclk); href = 1'b0; d = 8'h00;
  endtask

  task automatic run_frame(input int nl, input int nb);
    @(negedge pclk); vsync = 1'b0;
    cyc(3);
    for (int l = 0; l < nl; l++) begin send_line(nb); cyc(3); end
    @(negedge pclk); vsync = 1'b1;
    cyc(6);
  endtask

  task automatic test_reset();
    cyc(3);
    n_checks++; if (if_a.DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", if_a.DV); end
    n_checks++; if (if_a.o_pixel !== 16'h0) begin n_fail++; $display("FAIL reset_pixel got %h want 0000", if_a.o_pixel); end
    n_checks++; if (if_a.w_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", if_a.w_addr); end
    n_checks++; if (if_a.frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_fcnt got %h want 0", if_a.frame_count); end
    n_checks++; if ({if_a.SOF, if_a.FRAME_DONE, if_a.FRAME_ERR, if_a.LINE_ERR} !== 4'b0) begin
      n_fail++; $display("FAIL reset_status got %b want 0000", {if_a.SOF, if_a.FRAME_DONE, if_a.FRAME_ERR, if_a.LINE_ERR}); end
    n_checks++; if (2'(u_a.state_q) !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", u_a.state_q); end
    @(negedge pclk); rst = 1'b0; cen = 1'b1;
    cyc(4);
    n_checks++; if (2'(u_a.state_q) !== 2'd1) begin n_fail++; $display("FAIL armed_state got %0d want 1", u_a.state_q); end
  endtask

  task automatic test_frame_basic();
    take_base();
    run_frame(3, 8);
    n_checks++; if (dv_cnt[0] - b_dv[0] !== 12) begin n_fail++; $display("FAIL basic_dv got %0d want 12", dv_cnt[0] - b_dv[0]); end
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (addr_log[0][b_dv[0] + i] !== 4'(i)) begin
        n_fail++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr_log[0][b_dv[0] + i], i); end
    end
    n_checks++; if (pix_log[0][b_dv[0]] !== 16'h0102) begin n_fail++; $display("FAIL basic_first_pix got %h want 0102", pix_log[0][b_dv[0]]); end
    n_checks++; if (pix_log[0][b_dv[0] + 3] !== 16'h0708) begin n_fail++; $display("FAIL basic_pix3 got %h want 0708", pix_log[0][b_dv[0] + 3]); end
    n_checks++; if ({x_log[0][b_dv[0] + 5], y_log[0][b_dv[0] + 5]} !== 4'b01_01) begin
      n_fail++; $display("FAIL basic_xy5 got %b want 0101", {x_log[0][b_dv[0] + 5], y_log[0][b_dv[0] + 5]}); end
    n_checks++; if (sof_cnt[0] - b_sof[0] !== 1) begin n_fail++; $display("FAIL basic_sof got %0d want 1", sof_cnt[0] - b_sof[0]); end
    n_checks++; if (fd_cnt[0] - b_fd[0] !== 1) begin n_fail++; $display("FAIL basic_fd got %0d want 1", fd_cnt[0] - b_fd[0]); end
    n_checks++; if (fc_at_fd[0] !== 16'd1) begin n_fail++; $display("FAIL basic_fcnt got %0d want 1", fc_at_fd[0]); end
    n_checks++; if ((le_cnt[0] - b_le[0]) + (fe_cnt[0] - b_fe[0]) !== 0) begin
      n_fail++; $display("FAIL basic_errs got %0d want 0", (le_cnt[0] - b_le[0]) + (fe_cnt[0] - b_fe[0])); end
    n_checks++; if (dv_cnt[1] - b_dv[1] !== 12) begin n_fail++; $display("FAIL swap_dv got %0d want 12", dv_cnt[1] - b_dv[1]); end
    n_checks++; if (pix_log[1][b_dv[1]] !== 16'h0201) begin n_fail++; $display("FAIL swap_first_pix got %h want 0201", pix_log[1][b_dv[1]]); end
    n_checks++; if (pix_log[1][b_dv[1] + 3] !== 16'h0807) begin n_fail++; $display("FAIL swap_pix3 got %h want 0807", pix_log[1][b_dv[1] + 3]); end
  endtask

  task automatic test_short_line();
    logic [3:0] exp_addr[11];
    exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    take_base();
    @(negedge pclk); vsync = 1'b0;
    cyc(3);
    send_line(8); cyc(3);
    send_line(7);
    @(negedge pclk);
    n_checks++; if (if_a.LINE_ERR !== 1'b1) begin n_fail++; $display("FAIL short_lerr_pulse got %b want 1", if_a.LINE_ERR); end
    @(negedge pclk);
    n_checks++; if (if_a.LINE_ERR !== 1'b0) begin n_fail++; $display("FAIL short_lerr_width got %b want 0", if_a.LINE_ERR); end
    cyc(2);
    send_line(8); cyc(3);
    @(negedge pclk); vsync = 1'b1;
    cyc(6);
    n_checks++; if (dv_cnt[0] - b_dv[0] !== 11) begin n_fail++; $display("FAIL short_dv got %0d want 11", dv_cnt[0] - b_dv[0]); end
    for (int i = 0; i < 11; i++) begin
      n_checks++; if (addr_log[0][b_dv[0] + i] !== exp_addr[i]) begin
        n_fail++; $display("FAIL short_addr[%0d] got %0d want %0d", i, addr_log[0][b_dv[0] + i], exp_addr[i]); end
    end
    n_checks++; if (pix_log[0][b_dv[0] + 7] !== 16'h0102) begin n_fail++; $display("FAIL short_next_line_pix got %h want 0102", pix_log[0][b_dv[0] + 7]); end
    n_checks++; if (le_cnt[0] - b_le[0] !== 1) begin n_fail++; $display("FAIL short_lerr_cnt got %0d want 1", le_cnt[0] - b_le[0]); end
    n_checks++; if (fe_cnt[0] - b_fe[0] !== 0) begin n_fail++; $display("FAIL short_ferr got %0d want 0", fe_cnt[0] - b_fe[0]); end
    n_checks++; if (fc_at_fd[0] !== 16'd2) begin n_fail++; $display("FAIL short_fcnt got %0d want 2", fc_at_fd[0]); end
  endtask

  task automatic test_snapshot();
    @(negedge pclk); rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    take_base();
    @(negedge pclk); vsync = 1'b0;
    cyc(3);
    for (int l = 0; l < 3; l++) begin send_line(8); cyc(3); end
    @(negedge pclk); vsync = 1'b1;
    @(negedge pclk);
    n_checks++; if (if_c.FRAME_DONE !== 1'b1) begin n_fail++; $display("FAIL snap_fd got %b want 1", if_c.FRAME_DONE); end
    n_checks++; if (2'(u_c.state_q) !== 2'd0) begin n_fail++; $display("FAIL snap_idle got %0d want 0", u_c.state_q); end
    @(negedge pclk);
    n_checks++; if (2'(u_c.state_q) !== 2'd1) begin n_fail++; $display("FAIL snap_wait got %0d want 1", u_c.state_q); end
    cyc(4);
    run_frame(3, 8);
    n_checks++; if (dv_cnt[2] - b_dv[2] !== 12) begin n_fail++; $display("FAIL snap_dv got %0d want 12", dv_cnt[2] - b_dv[2]); end
    n_checks++; if (fd_cnt[2] - b_fd[2] !== 1) begin n_fail++; $display("FAIL snap_fd_cnt got %0d want 1", fd_cnt[2] - b_fd[2]); end
    n_checks++; if (dv_cnt[0] - b_dv[0] !== 24) begin n_fail++; $display("FAIL cont_dv got %0d want 24", dv_cnt[0] - b_dv[0]); end
    n_checks++; if (fc_at_fd[0] !== 16'd2) begin n_fail++; $display("FAIL cont_fcnt got %0d want 2", fc_at_fd[0]); end
  endtask

  task automatic test_reset_midframe();
    @(negedge pclk); vsync = 1'b0;
    cyc(3);
    send_line(8); cyc(3);
    for (int i = 0; i < 3; i++) begin @(negedge pclk); href = 1'b1; d = 8'(i + 1); end
    @(negedge pclk); rst = 1'b1; d = 8'h04;
    @(negedge pclk); d = 8'h05;
    n_checks++; if (if_a.DV !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dv got %b want 0", if_a.DV); end
    n_checks++; if (if_a.o_pixel !== 16'h0) begin n_fail++; $display("FAIL mid_rst_pixel got %h want 0000", if_a.o_pixel); end
    n_checks++; if ({if_a.w_addr, if_a.pixel_x, if_a.pixel_y} !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_coords got %h want 00", {if_a.w_addr, if_a.pixel_x, if_a.pixel_y}); end
    n_checks++; if (if_a.frame_count !== 16'h0) begin n_fail++; $display("FAIL mid_rst_fcnt got %0d want 0", if_a.frame_count); end
    @(negedge pclk); rst = 1'b0; d = 8'h06;
    take_base();
    @(negedge pclk); d = 8'h07;
    @(negedge pclk); d = 8'h08;
    @(negedge pclk); href = 1'b0; d = 8'h00;
    cyc(3);
    send_line(8); cyc(3);
    @(negedge pclk); vsync = 1'b1;
    cyc(6);
    n_checks++; if (dv_cnt[0] - b_dv[0] !== 0) begin n_fail++; $display("FAIL mid_partial_dv got %0d want 0", dv_cnt[0] - b_dv[0]); end
    n_checks++; if (fd_cnt[0] - b_fd[0] !== 0) begin n_fail++; $display("FAIL mid_partial_fd got %0d want 0", fd_cnt[0] - b_fd[0]); end
    take_base();
    run_frame(3, 8);
    n_checks++; if (dv_cnt[0] - b_dv[0] !== 12) begin n_fail++; $display("FAIL mid_next_dv got %0d want 12", dv_cnt[0] - b_dv[0]); end
    n_checks++; if ({addr_log[0][b_dv[0]], pix_log[0][b_dv[0]]} !== {4'd0, 16'h0102}) begin
      n_fail++; $display("FAIL mid_next_first got %h want 00102", {addr_log[0][b_dv[0]], pix_log[0][b_dv[0]]}); end
    n_checks++; if (sof_cnt[0] - b_sof[0] !== 1) begin n_fail++; $display("FAIL mid_next_sof got %0d want 1", sof_cnt[0] - b_sof[0]); end
    n_checks++; if (fc_at_fd[0] !== 16'd1) begin n_fail++; $display("FAIL mid_next_fcnt got %0d want 1", fc_at_fd[0]); end
  endtask

  task automatic test_bpp1_overrun();
    take_base();
    run_frame(4, 5);
    n_checks++; if (dv_cnt[3] - b_dv[3] !== 12) begin n_fail++; $display("FAIL bpp1_dv got %0d want 12", dv_cnt[3] - b_dv[3]); end
    n_checks++; if (pix_log[3][b_dv[3]] !== 16'h0001) begin n_fail++; $display("FAIL bpp1_first_pix got %h want 0001", pix_log[3][b_dv[3]]); end
    n_checks++; if (pix_log[3][b_dv[3] + 3] !== 16'h0004) begin n_fail++; $display("FAIL bpp1_pix3 got %h want 0004", pix_log[3][b_dv[3] + 3]); end
    n_checks++; if ({addr_log[3][b_dv[3] + 4], pix_log[3][b_dv[3] + 4]} !== {4'd4, 16'h0001}) begin
      n_fail++; $display("FAIL bpp1_line1 got %h want 40001", {addr_log[3][b_dv[3] + 4], pix_log[3][b_dv[3] + 4]}); end
    n_checks++; if ({addr_log[3][b_dv[3] + 11], y_log[3][b_dv[3] + 11]} !== {4'd11, 2'd2}) begin
      n_fail++; $display("FAIL bpp1_last got %h want 2e", {addr_log[3][b_dv[3] + 11], y_log[3][b_dv[3] + 11]}); end
    n_checks++; if (le_cnt[3] - b_le[3] !== 4) begin n_fail++; $display("FAIL bpp1_lerr got %0d want 4", le_cnt[3] - b_le[3]); end
    n_checks++; if (fd_cnt[3] - b_fd[3] !== 1) begin n_fail++; $display("FAIL bpp1_fd got %0d want 1", fd_cnt[3] - b_fd[3]); end
    n_checks++; if (fefd_cnt[3] - b_fefd[3] !== 1) begin n_fail++; $display("FAIL bpp1_ferr got %0d want 1", fefd_cnt[3] - b_fefd[3]); end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; vsync = 1'b1; href = 1'b0; d = 8'h00;
    test_reset();
    test_frame_basic();
    test_short_line();
    test_snapshot();
    test_reset_midframe();
    test_bpp1_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
